key_debounce_multi: RTL and testbench

//  Parametrised successor to the keypad debouncer. It synchronises a WIDTH-bit raw key/switch

---
 rtl/key_debounce_multi.sv | 147 ++++++++++++++
 tb/tb_key_debounce_multi.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// Synchronising multi-channel key debouncer with edge pulses and a valid/ack press register.
// MODE=0 debounces the whole vector as one code word; MODE=1 debounces every bit on its own.
module key_debounce_multi #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 1000000,
    parameter int SYNC_STAGES   = 2,
    parameter int MODE          = 0,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] key_in,
    output logic [WIDTH-1:0] debounced_key,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             data_available,
    output logic [WIDTH-1:0] code_out,
    output logic             code_valid,
    input  logic             code_ack,
    output logic             overrun
);

    localparam int UNITS = (MODE == 0) ? 1 : WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] s_key_s;
    logic [WIDTH-1:0] deb_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic             press_s;
    logic [WIDTH-1:0] code_next_s;
    logic             valid_next_s;
    logic             overrun_next_s;

    // Metastability synchroniser chain for the raw pins.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= key_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign s_key_s = sync_r[SYNC_STAGES-1];

    genvar u;
    generate
        for (u = 0; u < UNITS; u++) begin : g_unit
            // In vector mode one unit spans every bit so the word can only change atomically.
            localparam int LO = (MODE == 0) ? 0 : u;
            localparam int HI = (MODE == 0) ? WIDTH - 1 : u;
            localparam int UW = HI - LO + 1;

            logic [UW-1:0]    s_u_s;
            logic [UW-1:0]    cand_r;
            logic [UW-1:0]    deb_r;
            logic [CNT_W-1:0] cnt_r;

            assign s_u_s = s_key_s[HI:LO];

            // Candidate tracking and stability counter; any change restarts the count.
            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset) begin
                    cand_r <= {UW{1'b0}};
                    deb_r  <= {UW{1'b0}};
                    cnt_r  <= {CNT_W{1'b0}};
                end else if (s_u_s != cand_r) begin
                    cand_r <= s_u_s;
                    cnt_r  <= {CNT_W{1'b0}};
                end else if (cand_r != deb_r) begin
                    if (cnt_r == CNT_MAX) begin
                        deb_r <= cand_r;
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            end

            assign deb_s[HI:LO] = deb_r;
        end
    endgenerate

    // Edge and press detection against the currently presented level.
    always_comb begin
        rise_s  = deb_s & ~debounced_key;
        fall_s  = ~deb_s & debounced_key;
        press_s = 1'b0;
        if (MODE == 0) begin
            press_s = (deb_s != debounced_key) && (deb_s != {WIDTH{1'b0}});
        end else begin
            press_s = |rise_s;
        end
    end

    // Press register: oldest unacknowledged code wins, a lost press sets overrun.
    always_comb begin
        code_next_s    = code_out;
        valid_next_s   = code_valid;
        overrun_next_s = overrun;
        if (press_s) begin
            if (!code_valid) begin
                code_next_s  = deb_s;
                valid_next_s = 1'b1;
            end else if (code_ack) begin
                code_next_s = deb_s;
            end else begin
                overrun_next_s = 1'b1;
            end
        end else if (code_ack && code_valid) begin
            valid_next_s   = 1'b0;
            overrun_next_s = 1'b0;
        end else begin
            valid_next_s = code_valid;
        end
    end

    // Output registers; the level, its pulses and the press event all land on one edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            debounced_key  <= {WIDTH{1'b0}};
            rise_pulse     <= {WIDTH{1'b0}};
            fall_pulse     <= {WIDTH{1'b0}};
            data_available <= 1'b0;
            code_out       <= {WIDTH{1'b0}};
            code_valid     <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            debounced_key  <= deb_s;
            rise_pulse     <= rise_s;
            fall_pulse     <= fall_s;
            data_available <= press_s;
            code_out       <= code_next_s;
            code_valid     <= valid_next_s;
            overrun        <= overrun_next_s;
        end
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: one vector-mode and one per-bit-mode instance
// (STABLE_CYCLES=8, SYNC_STAGES=2, WIDTH=4) driven mid-cycle and sampled mid-cycle.
module tb_key_debounce_multi;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [3:0] key0, key1;
    logic       ack0, ack1;
    logic [3:0] db0, rp0, fp0, co0;
    logic [3:0] db1, rp1, fp1, co1;
    logic       da0, cv0, ov0, da1, cv1, ov1;

    int n_checks = 0;
    int n_fails  = 0;
    int cnt_da, cnt_rise, cnt_nz;

    always #10 clk = ~clk;

    key_debounce_multi #(.WIDTH(4), .STABLE_CYCLES(8), .SYNC_STAGES(2), .MODE(0)) dut0 (
        .clk(clk), .n_reset(n_reset), .key_in(key0), .debounced_key(db0),
        .rise_pulse(rp0), .fall_pulse(fp0), .data_available(da0), .code_out(co0),
        .code_valid(cv0), .code_ack(ack0), .overrun(ov0));

    key_debounce_multi #(.WIDTH(4), .STABLE_CYCLES(8), .SYNC_STAGES(2), .MODE(1)) dut1 (
        .clk(clk), .n_reset(n_reset), .key_in(key1), .debounced_key(db1),
        .rise_pulse(rp1), .fall_pulse(fp1), .data_available(da1), .code_out(co1),
        .code_valid(cv1), .code_ack(ack1), .overrun(ov1));

    task automatic step();
        @(posedge clk);
        #5;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_reset = 1'b0;
        key0 = 4'b0000; key1 = 4'b0000;
        ack0 = 1'b0;    ack1 = 1'b0;
        steps(2);
        chk("reset_db", {28'd0, db0}, 32'd0);
        chk("reset_valid", {31'd0, cv0}, 32'd0);
        n_reset = 1'b1;

        // Clean step 0000 -> 0001
        key0 = 4'b0001;
        steps(11);
        chk("step_db_edge10", {28'd0, db0}, 32'd0);
        step();
        chk("step_db_edge11", {28'd0, db0}, 32'd1);
        chk("step_rise", {28'd0, rp0}, 32'd1);
        chk("step_da", {31'd0, da0}, 32'd1);
        step();
        chk("step_da_1clk", {31'd0, da0}, 32'd0);
        chk("step_rise_1clk", {28'd0, rp0}, 32'd0);
        chk("step_code", {28'd0, co0}, 32'd1);
        chk("step_valid", {31'd0, cv0}, 32'd1);

        // Reset in the middle of a count
        key0 = 4'b0101;
        steps(5);
        n_reset = 1'b0;
        #1;
        chk("rst_db_now", {28'd0, db0}, 32'd0);
        chk("rst_valid_now", {31'd0, cv0}, 32'd0);
        chk("rst_code_now", {28'd0, co0}, 32'd0);
        chk("rst_pulses_now", {24'd0, rp0, fp0}, 32'd0);
        #1;
        steps(2);
        n_reset = 1'b1;
        steps(11);
        chk("rst_restart_edge10", {28'd0, db0}, 32'd0);
        step();
        chk("rst_restart_db", {28'd0, db0}, 32'h5);
        chk("rst_restart_rise", {28'd0, rp0}, 32'h5);
        chk("rst_restart_fall", {28'd0, fp0}, 32'h0);
        chk("rst_restart_da", {31'd0, da0}, 32'd1);
        step();

        // Ack clears, then nonzero -> nonzero press
        ack0 = 1'b1; step(); ack0 = 1'b0;
        chk("ack_valid", {31'd0, cv0}, 32'd0);
        chk("ack_code_kept", {28'd0, co0}, 32'h5);
        key0 = 4'b0100;
        steps(12);
        chk("p0100_da", {31'd0, da0}, 32'd1);
        chk("p0100_fall", {28'd0, fp0}, 32'h1);
        chk("p0100_rise", {28'd0, rp0}, 32'h0);
        chk("p0100_code", {28'd0, co0}, 32'h4);
        step();
        key0 = 4'b1010;
        steps(12);
        chk("p1010_db", {28'd0, db0}, 32'ha);
        chk("p1010_code_kept", {28'd0, co0}, 32'h4);
        chk("p1010_overrun", {31'd0, ov0}, 32'd1);
        step();
        ack0 = 1'b1; step(); ack0 = 1'b0;
        chk("ack2_valid", {31'd0, cv0}, 32'd0);
        chk("ack2_overrun", {31'd0, ov0}, 32'd0);
        key0 = 4'b0011;
        steps(13);
        chk("p0011_code", {28'd0, co0}, 32'h3);
        key0 = 4'b0110;
        steps(11);
        ack0 = 1'b1; step(); ack0 = 1'b0;
        chk("ackpress_code", {28'd0, co0}, 32'h6);
        chk("ackpress_valid", {31'd0, cv0}, 32'd1);
        chk("ackpress_overrun", {31'd0, ov0}, 32'd0);
        step();
        key0 = 4'b0000;
        steps(12);
        chk("release_db", {28'd0, db0}, 32'h0);
        chk("release_fall", {28'd0, fp0}, 32'h6);
        chk("release_da", {31'd0, da0}, 32'd0);
        chk("release_valid", {31'd0, cv0}, 32'd1);
        chk("release_code", {28'd0, co0}, 32'h6);
        step();

        // Bounce: 1,0,1,0 three clocks each, then held high
        cnt_da = 0; cnt_rise = 0;
        for (int k = 0; k < 28; k++) begin
            key0 = (k < 12) ? (((k / 3) % 2 == 0) ? 4'b0001 : 4'b0000) : 4'b0001;
            step();
            cnt_da   += int'(da0);
            cnt_rise += int'(rp0[0]);
            if (k == 22) chk("bounce_edge10", {28'd0, db0}, 32'h0);
            if (k == 23) chk("bounce_edge11", {28'd0, db0}, 32'h1);
        end
        chk("bounce_one_da", cnt_da, 32'd1);
        chk("bounce_one_rise", cnt_rise, 32'd1);
        chk("bounce_overrun", {31'd0, ov0}, 32'd1);
        chk("bounce_code_kept", {28'd0, co0}, 32'h6);

        // Glitch of STABLE_CYCLES-1 clocks
        ack0 = 1'b1; step(); ack0 = 1'b0;
        key0 = 4'b0000;
        steps(13);
        chk("glitch_base", {28'd0, db0}, 32'h0);
        cnt_da = 0; cnt_rise = 0; cnt_nz = 0;
        for (int k = 0; k < 27; k++) begin
            key0 = (k < 7) ? 4'b1010 : 4'b0000;
            step();
            cnt_da   += int'(da0);
            cnt_rise += int'(|rp0);
            cnt_nz   += int'(|db0);
        end
        chk("glitch_da", cnt_da, 32'd0);
        chk("glitch_rise", cnt_rise, 32'd0);
        chk("glitch_db", cnt_nz, 32'd0);

        // Per-bit mode: bit0 steady, bit2 chattering
        key1 = 4'b0001;
        for (int k = 0; k < 21; k++) begin
            key1[2] = (k < 12) ? ((k / 3) % 2 == 1) : 1'b1;
            step();
            if (k == 10) chk("m1_edge10", {28'd0, db1}, 32'h0);
            if (k == 11) begin
                chk("m1_bit0_db", {28'd0, db1}, 32'h1);
                chk("m1_bit0_rise", {28'd0, rp1}, 32'h1);
                chk("m1_bit0_da", {31'd0, da1}, 32'd1);
            end
            if (k == 19) chk("m1_bit2_wait", {28'd0, db1}, 32'h1);
            if (k == 20) begin
                chk("m1_bit2_db", {28'd0, db1}, 32'h5);
                chk("m1_bit2_rise", {28'd0, rp1}, 32'h4);
                chk("m1_bit2_da", {31'd0, da1}, 32'd1);
            end
        end
        chk("m1_code", {28'd0, co1}, 32'h1);
        chk("m1_overrun", {31'd0, ov1}, 32'd1);
        key1 = 4'b0100;
        steps(11);
        chk("m1_fall_early", {28'd0, fp1}, 32'h0);
        step();
        chk("m1_fall", {28'd0, fp1}, 32'h1);
        chk("m1_fall_db", {28'd0, db1}, 32'h4);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
